// File: rtl/and16_arb_if.sv
// Requester and response channels shared by the and16 arbiter and its clients.
interface and16_arb_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [15:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/and16_arbiter.sv
// Shares one 16-bit AND datapath between N_REQ valid/ready requesters.
// AND16_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (lowest index wins).
module and16_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input logic       clk,
  input logic       reset,
  and16_arb_if.slave bus
);
  localparam int unsigned IDW = $clog2(N_REQ);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e         state_q;
  logic [15:0]    a_q;
  logic [15:0]    b_q;
  logic [IDW-1:0] id_q;
  logic           can_accept;
  logic           found;
  logic           accept;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0] win;
  logic [IDW-1:0] sel;
`ifdef AND16_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q;
  logic [IDW:0]   sum;
`endif

  assign can_accept = !reset && ((state_q == StIdle) || bus.rsp_ready);
  assign accept     = can_accept && found;

  // First valid requester found while scanning upward from the search start.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    sel   = '0;
`ifdef AND16_ARB_ROUND_ROBIN_EN
    sum   = '0;
`endif
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef AND16_ARB_ROUND_ROBIN_EN
      sum = (IDW+1)'(k) + {1'b0, ptr_q};
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      sel = sum[IDW-1:0];
`else
      sel = IDW'(k);
`endif
      if (!found && bus.req_valid[sel]) begin
        found      = 1'b1;
        win        = sel;
        grant[sel] = 1'b1;
      end
    end
  end

  assign bus.req_ready = can_accept ? grant : '0;
  assign bus.rsp_valid = (state_q == StResp);
  // The single shared AND16 datapath.
  assign bus.rsp_data  = a_q & b_q;
  assign bus.rsp_id    = id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
`ifdef AND16_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else if (accept) begin
      state_q <= StResp;
      a_q     <= bus.req_a[{win, 4'b0000} +: 16];
      b_q     <= bus.req_b[{win, 4'b0000} +: 16];
      id_q    <= win;
`ifdef AND16_ARB_ROUND_ROBIN_EN
      ptr_q   <= (32'(win) + 1 == N_REQ) ? '0 : win + 1'b1;
`endif
    end else if ((state_q == StResp) && bus.rsp_ready) begin
      state_q <= StIdle;
    end
  end
endmodule

// File: doc/and16_arbiter.md
# and16_arbiter

Round-robin arbiter that shares a single `And16` instance between `N_REQ` requesters. Each requester uses a valid/ready handshake. The block registers the granted operand pair and returns the 16-bit AND result together with the requester ID on one response channel, which also uses valid/ready. It sits between the control units that need bitwise masking (flag masking, address alignment) and the one `And16` datapath instance, so only one `And16` is instantiated.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(N_REQ)`: width of `rsp_id`; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept strobe; at most one bit set.
- `req_a`  in  16*N_REQ  operand a; requester i uses bits [16i+15:16i].
- `req_b`  in  16*N_REQ  operand b; same packing as `req_a`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  16  `a & b` of the accepted request.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`.

## Operation
- State machine has two states:
  - IDLE: no result held.
  - RESP: result held, `rsp_valid`=1.
- Acceptance condition: `can_accept` = (IDLE) or (RESP and `rsp_ready`). While `reset` is high, `can_accept` = 0.
- Grant selection:
  - `grant` is a one-hot pick among set `req_valid` bits.
  - Search starts at pointer `ptr` and wraps modulo `N_REQ`.
  - `req_ready` = `grant` when `can_accept`, else 0. This path is combinational from `req_valid`.
- On acceptance (any `req_ready` bit high at the edge):
  - Operand registers capture `req_a`/`req_b` of the winner.
  - `rsp_id` register captures the winner index.
  - `ptr` ← winner+1 (mod `N_REQ`).
  - State → RESP.
- `rsp_data` = `And16(a_reg, b_reg)`. It is combinational from the registers, so it is stable for the whole RESP period.
- In RESP with `rsp_ready`=1 and no valid request, state → IDLE.
- In RESP with `rsp_ready`=1 and a valid request:
  - The new request is accepted in the same cycle.
  - State stays RESP with new contents, giving back-to-back throughput of 1 per cycle.
- In RESP with `rsp_ready`=0, all registers hold. `req_ready` is all 0.
- Requester rules:
  - A requester must hold `req_valid`, `req_a` and `req_b` stable until it sees `req_ready`.
  - Dropping `req_valid` early is permitted. It simply removes that requester from arbitration.
- A requester with `req_valid` held high continuously is granted again only after every other valid requester has been served once (no starvation).

## Timing
- Reset values:
  - State IDLE.
  - `ptr`=0.
  - `a_reg`=`b_reg`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0.
  - `req_ready`=0 while `reset` is high.
- Latency: a request accepted at edge T gives `rsp_valid`=1 for the cycle following T, with the correct data and ID.
- Reset mid-operation: a held result is discarded with no response. The pointer returns to 0. A requester that was waiting keeps waiting and is not considered accepted.
- Simultaneous `rsp_ready` and requests: this is the response handshake and the acceptance happening in the same edge, as described above. No bubble is inserted.
- Pointer wrap: after grant to `N_REQ`-1, `ptr`=0.

## Configuration
- Macro: `AND16_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration as described in Operation.
- Not defined:
  - Fixed priority; the lowest set index always wins.
  - `ptr` is not implemented and stays 0.
  - The starvation guarantee does not apply.
- All other behaviour, latency and reset values are identical in both builds.

## Test plan
- Reset check: hold `reset`=1 for 3 cycles with all `req_valid` set. Required: `req_ready`=0, `rsp_valid`=0, `rsp_data`=16'h0000, `rsp_id`=0 throughout.
- Single request: req0 with a=16'h3CC3, b=16'h0FF0, `rsp_ready`=1. Required: `req_ready`[0]=1 for one cycle; next cycle `rsp_valid`=1, `rsp_data`=16'h0CC0, `rsp_id`=0.
- Backpressure: req2 with a=16'h1234, b=16'h9876, `rsp_ready`=0 for 5 cycles. Required: `rsp_data`=16'h1034 and `rsp_id`=2 held stable; `req_ready`=0 for requesters 1 and 3, which are valid during that time; then `rsp_ready`=1 completes the transfer.
- Round robin (macro defined): all four requesters valid, with a=b=16'hFFFF, 16'hAAAA, 16'h5555, 16'h0F0F respectively, and `rsp_ready`=1. Required: grants 0,1,2,3,0 on consecutive cycles, `rsp_id` sequence 0,1,2,3,0, one result per cycle.
- Fixed priority (macro undefined): req0 and req3 held valid, `rsp_ready`=1. Required: every grant goes to 0 and req3 is never accepted.
- Reset mid-operation: accept req1 (a=16'hAAAA, b=16'h5555), hold `rsp_ready`=0, pulse `reset` for 1 cycle. Required: `rsp_valid`=0 the cycle after reset. With req1 still valid, it is re-accepted and returns `rsp_data`=16'h0000, `rsp_id`=1.
